// File: rtl/playback_address_sequencer.sv
// Playback address sequencer: walks a sample address through a configurable
// window [start,end] in steps of `step`, forward or reverse, either looping at
// the window edge or stopping there.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | window loaded (or reset), waiting for play
//   S_PLAY  | advancing the address on each advance strobe
//   S_PAUSE | playback halted, address held, resumes on play
//   S_DONE  | non-looping playback reached the window edge
//
// Strobe priority within a cycle: rst > load > pause > play > advance.
module playback_address_sequencer #(
   parameter int               WIDTH     = 23,
   parameter int               STEP_W    = 4,
   parameter logic [WIDTH-1:0] RESET_END = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [WIDTH-1:0]  cfg_start,
   input  logic [WIDTH-1:0]  cfg_end,
   input  logic [STEP_W-1:0] cfg_step,
   input  logic              load,
   input  logic              play,
   input  logic              pause,
   input  logic              forward,
   input  logic              loop_en,
   input  logic              advance,
   output logic [WIDTH-1:0]  address,
   output logic              playing,
   output logic              wrap,
   output logic              done,
   output logic              cfg_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PLAY  = 2'd1,
      S_PAUSE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t             state;
   logic [WIDTH-1:0]   start_q;
   logic [WIDTH-1:0]   end_q;
   logic [STEP_W-1:0]  step_q;

   logic [WIDTH:0]     step_ext;
   logic [WIDTH:0]     sum;
   logic [WIDTH:0]     diff;
   logic               fwd_over;
   logic               rev_under;
   logic               out_of_win;
   logic               cfg_ok;
   logic [STEP_W-1:0]  load_step;
   logic [WIDTH-1:0]   edge_addr;

   // Next-address arithmetic is carried one bit wider so that overrun past
   // the top of the address space and underrun below zero are both detected.
   always_comb begin
      step_ext   = {{(WIDTH + 1 - STEP_W){1'b0}}, step_q};
      sum        = {1'b0, address} + step_ext;
      diff       = {1'b0, address} - step_ext;
      fwd_over   = sum > {1'b0, end_q};
      rev_under  = diff[WIDTH] | (diff[WIDTH-1:0] < start_q);
      out_of_win = (address < start_q) | (address > end_q);
      cfg_ok     = cfg_start <= cfg_end;
      load_step  = (cfg_step == '0) ? {{(STEP_W-1){1'b0}}, 1'b1} : cfg_step;
      edge_addr  = forward ? start_q : end_q;
   end

   // Sequencer FSM with registered address and status pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         address <= '0;
         start_q <= '0;
         end_q   <= RESET_END;
         step_q  <= {{(STEP_W-1){1'b0}}, 1'b1};
         playing <= 1'b0;
         wrap    <= 1'b0;
         done    <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         wrap    <= 1'b0;
         done    <= 1'b0;
         cfg_err <= 1'b0;
         if (load) begin
            // a rejected window leaves everything, including state, untouched
            if (cfg_ok) begin
               start_q <= cfg_start;
               end_q   <= cfg_end;
               step_q  <= load_step;
               address <= forward ? cfg_start : cfg_end;
               state   <= S_IDLE;
               playing <= 1'b0;
            end else begin
               cfg_err <= 1'b1;
            end
         end else if (pause) begin
            if (state == S_PLAY) begin
               state   <= S_PAUSE;
               playing <= 1'b0;
            end
         end else if (play) begin
            if (state != S_PLAY) begin
               state   <= S_PLAY;
               playing <= 1'b1;
               // restarting after completion rewinds to the leading edge
               if (state == S_DONE) begin
                  address <= edge_addr;
               end
            end
         end else if (advance && (state == S_PLAY)) begin
            if (out_of_win) begin
               address <= edge_addr;
            end else if (forward) begin
               if (!fwd_over) begin
                  address <= sum[WIDTH-1:0];
               end else if (loop_en) begin
                  address <= start_q;
                  wrap    <= 1'b1;
               end else begin
                  address <= end_q;
                  state   <= S_DONE;
                  playing <= 1'b0;
                  done    <= 1'b1;
               end
            end else begin
               if (!rev_under) begin
                  address <= diff[WIDTH-1:0];
               end else if (loop_en) begin
                  address <= end_q;
                  wrap    <= 1'b1;
               end else begin
                  address <= start_q;
                  state   <= S_DONE;
                  playing <= 1'b0;
                  done    <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_playback_address_sequencer.sv
// Scoreboard bench: each driven cycle pushes the reference model's expected
// outputs; a monitor pops and compares after every clock edge.
module tb_playback_address_sequencer;

   localparam int             W  = 8;
   localparam int             SW = 4;
   localparam logic [W-1:0]   RE = 8'd200;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [W-1:0]  cs = '0;
   logic [W-1:0]  ce = '0;
   logic [SW-1:0] cst = '0;
   logic          load = 1'b0;
   logic          play = 1'b0;
   logic          pause = 1'b0;
   logic          dir = 1'b1;
   logic          lp = 1'b0;
   logic          advance = 1'b0;
   logic [W-1:0]  address;
   logic          playing;
   logic          wrap;
   logic          done;
   logic          cfg_err;

   playback_address_sequencer #(.WIDTH(W), .STEP_W(SW), .RESET_END(RE)) dut (
      .clk(clk), .rst(rst), .cfg_start(cs), .cfg_end(ce), .cfg_step(cst),
      .load(load), .play(play), .pause(pause), .forward(dir), .loop_en(lp),
      .advance(advance), .address(address), .playing(playing), .wrap(wrap),
      .done(done), .cfg_err(cfg_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int addr;
      int playing;
      int wrap;
      int done;
      int err;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_DONE = 3;
   int m_addr, m_start, m_end, m_step, m_st;

   task automatic cmp(input string n, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d", n, got, want);
      end
   endtask

   // Reference behaviour written directly from the window/step rules.
   task automatic model(input bit r, input bit ld, input bit pl, input bit pa,
                        input bit ad, output exp_t e);
      int s;
      e.wrap = 0;
      e.done = 0;
      e.err  = 0;
      if (r) begin
         m_addr = 0; m_start = 0; m_end = int'(RE); m_step = 1; m_st = M_IDLE;
      end else if (ld) begin
         if (int'(cs) <= int'(ce)) begin
            m_start = int'(cs);
            m_end   = int'(ce);
            m_step  = (cst == 0) ? 1 : int'(cst);
            m_st    = M_IDLE;
            m_addr  = dir ? m_start : m_end;
         end else begin
            e.err = 1;
         end
      end else if (pa) begin
         if (m_st == M_PLAY) m_st = M_PAUSE;
      end else if (pl) begin
         if (m_st == M_DONE) m_addr = dir ? m_start : m_end;
         m_st = M_PLAY;
      end else if (ad && m_st == M_PLAY) begin
         if (m_addr < m_start || m_addr > m_end) begin
            m_addr = dir ? m_start : m_end;
         end else if (dir) begin
            s = m_addr + m_step;
            if (s <= m_end) m_addr = s;
            else if (lp) begin m_addr = m_start; e.wrap = 1; end
            else begin m_addr = m_end; m_st = M_DONE; e.done = 1; end
         end else begin
            s = m_addr - m_step;
            if (s >= m_start) m_addr = s;
            else if (lp) begin m_addr = m_end; e.wrap = 1; end
            else begin m_addr = m_start; m_st = M_DONE; e.done = 1; end
         end
      end
      e.addr    = m_addr;
      e.playing = (m_st == M_PLAY) ? 1 : 0;
   endtask

   // Drive one cycle at the falling edge, queue its expectation, and return
   // just after the rising edge that samples it.
   task automatic cyc(input bit r, input bit ld, input bit pl, input bit pa, input bit ad);
      exp_t e;
      @(negedge clk);
      rst = r; load = ld; play = pl; pause = pa; advance = ad;
      model(r, ld, pl, pa, ad, e);
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic dchk(input string n, input int a, input int p, input int w,
                       input int d, input int er);
      cmp({n, ".address"}, int'(address), a);
      cmp({n, ".playing"}, int'(playing), p);
      cmp({n, ".wrap"}, int'(wrap), w);
      cmp({n, ".done"}, int'(done), d);
      cmp({n, ".cfg_err"}, int'(cfg_err), er);
   endtask

   // Monitor: compare every presented output against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            cmp("sb.address", int'(address), e.addr);
            cmp("sb.playing", int'(playing), e.playing);
            cmp("sb.wrap", int'(wrap), e.wrap);
            cmp("sb.done", int'(done), e.done);
            cmp("sb.cfg_err", int'(cfg_err), e.err);
         end
      end
   end

   initial begin
      cyc(1, 0, 0, 0, 0);
      dchk("reset", 0, 0, 0, 0, 0);

      // forward, no loop: 13, 16, 19, then 20 with done
      cs = 10; ce = 20; cst = 3; dir = 1; lp = 0;
      cyc(0, 1, 0, 0, 0);
      dchk("load_fwd", 10, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 1); dchk("fwd1", 13, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 1); dchk("fwd2", 16, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 1); dchk("fwd3", 19, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 1); dchk("fwd_done", 20, 0, 0, 1, 0);
      cyc(0, 0, 0, 0, 0); dchk("done_once", 20, 0, 0, 0, 0);

      // forward loop: 19 -> 10 with wrap
      lp = 1;
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      repeat (3) cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1); dchk("fwd_wrap", 10, 1, 1, 0, 0);
      cyc(0, 0, 0, 0, 0); dchk("wrap_once", 10, 1, 0, 0, 0);

      // reverse: 11 -> 20 wrap, then 11 -> 10 done
      dir = 0;
      cyc(0, 1, 0, 0, 0); dchk("load_rev", 20, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      repeat (3) cyc(0, 0, 0, 0, 1);
      dchk("rev_at11", 11, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 1); dchk("rev_wrap", 20, 1, 1, 0, 0);
      lp = 0;
      repeat (3) cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1); dchk("rev_done", 10, 0, 0, 1, 0);

      // rejected load keeps old window
      cs = 30; ce = 5; cst = 7;
      cyc(0, 1, 0, 0, 0); dchk("bad_load", 10, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 0); dchk("err_once", 10, 0, 0, 0, 0);
      dir = 1;
      cyc(0, 0, 1, 0, 0); dchk("replay", 10, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 1); dchk("old_step", 13, 1, 0, 0, 0);

      // pause wins over advance; advances ignored until play
      cyc(0, 0, 0, 1, 1); dchk("pause_adv", 13, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1); dchk("paused_adv", 13, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 1); dchk("resume", 16, 1, 0, 0, 0);

      // reset beats load and advance
      cs = 10; ce = 20; lp = 1;
      cyc(1, 1, 0, 0, 1); dchk("rst_mid", 0, 0, 0, 0, 0);
      // reset window ends at RESET_END: reverse from 0 wraps there
      dir = 0;
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 1); dchk("reset_end", 200, 1, 1, 0, 0);

      // single-point window
      cs = 50; ce = 50; cst = 5; dir = 1; lp = 1;
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 1); dchk("point_wrap", 50, 1, 1, 0, 0);
      lp = 0;
      cyc(0, 0, 0, 0, 1); dchk("point_done", 50, 0, 0, 1, 0);

      // sum past the top of the address space
      cs = 250; ce = 255; cst = 15;
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 1); dchk("top_over", 255, 0, 0, 1, 0);

      // zero step behaves as one
      cs = 0; ce = 3; cst = 0;
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 1); dchk("step0", 1, 1, 0, 0, 0);

      // randomized traffic checked through the scoreboard
      for (int i = 0; i < 3000; i++) begin
         cs  = W'($urandom_range(0, 255));
         ce  = W'($urandom_range(0, 255));
         if ($urandom_range(0, 3) != 0 && cs > ce) begin
            logic [W-1:0] t;
            t = cs; cs = ce; ce = t;
         end
         cst = SW'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) dir = ~dir;
         if ($urandom_range(0, 29) == 0) lp = ~lp;
         cyc($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 3,
             $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 4,
             $urandom_range(0, 99) < 60);
      end

      repeat (3) @(posedge clk);
      #2;
      cmp("queue_drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
